mem_rr_arbiter: RTL

//  Round-robin arbiter that shares the single memory port (valid/ready, wr_rd, addr, wdata, rdata)

---
 rtl/mem_rr_arbiter_if.sv | 36 +++
 rtl/mem_rr_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter_if.sv
// Memory-side bus of the round-robin arbiter.
//   valid  master->slave  request valid
//   wr_rd  master->slave  1=write 0=read
//   addr   master->slave  address
//   wdata  master->slave  write data
//   ready  slave->master  transfer accepted/completed
//   rdata  slave->master  read data, valid in the cycle ready=1 for reads
interface mem_rr_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WIDTH      = 16
);
    logic                  valid;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  ready;
    logic [WIDTH-1:0]      rdata;

    modport master (
        output valid,
        output wr_rd,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  wr_rd,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters.
// One request is captured at a time, driven on the memory port until ready, and the
// completion (read data or write ack) is returned to its owner. A transfer stalled for
// TIMEOUT cycles is aborted and reported with rsp_err.
//   clk        clock, posedge
//   rst        asynchronous active-low reset
//   req_valid  per-requester request pending
//   req_wr_rd  per-requester 1=write 0=read
//   req_addr   flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  flattened write data, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot accept pulse (combinational)
//   rsp_valid  one-hot completion pulse (registered)
//   rsp_err    completion was a timeout abort
//   rsp_rdata  read data of the last completion
//   mem        memory port (master side)
module mem_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [WIDTH-1:0]              rsp_rdata,
    mem_rr_arbiter_if.master              mem
);

    localparam int unsigned PtrW   = $clog2(NUM_REQ);
    localparam int unsigned TimerW = $clog2(TIMEOUT) + 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic [PtrW-1:0]        owner_q, owner_d;
    logic [TimerW-1:0]      timer_q, timer_d;
    logic                   valid_q, valid_d;
    logic                   wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;

    logic                   grant_found;
    logic [PtrW-1:0]        grant_idx;
    logic [NUM_REQ-1:0]     grant_ready;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        int unsigned cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[PtrW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = PtrW'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        timer_d     = timer_q;
        valid_d     = valid_q;
        wr_rd_d     = wr_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        grant_ready = '0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    grant_ready = (NUM_REQ)'(1) << grant_idx;
                    wr_rd_d     = req_wr_rd[grant_idx];
                    addr_d      = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d     = req_wdata[grant_idx*WIDTH +: WIDTH];
                    valid_d     = 1'b1;
                    owner_d     = grant_idx;
                    ptr_d       = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    timer_d     = '0;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                // ready wins over a timeout landing in the same cycle
                if (mem.ready) begin
                    valid_d     = 1'b0;
                    rsp_valid_d = (NUM_REQ)'(1) << owner_q;
                    rsp_rdata_d = wr_rd_q ? '0 : mem.rdata;
                    state_d     = StIdle;
                end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
                    valid_d     = 1'b0;
                    rsp_valid_d = (NUM_REQ)'(1) << owner_q;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            timer_q     <= '0;
            valid_q     <= 1'b0;
            wr_rd_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            timer_q     <= timer_d;
            valid_q     <= valid_d;
            wr_rd_q     <= wr_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Accept pulse is combinational, so mask it while reset is asserted.
    assign req_ready = grant_ready & {NUM_REQ{rst}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    assign mem.valid = valid_q;
    assign mem.wr_rd = wr_rd_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

endmodule
